// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - handshake/stream bundle for the serial pattern transmitter
// Purpose: groups the frame request, step control and serial/status outputs.
// Ports (modport slave = transmitter, master = driver):
//   start, data[WIDTH-1:0], step          : driver -> transmitter
//   w_out, busy, done, bits_left, run_len, z_expect : transmitter -> driver
interface seq_pattern_tx_if #(
  parameter int WIDTH = 8
);
  localparam int BW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] data;
  logic             step;
  logic             w_out;
  logic             busy;
  logic             done;
  logic [BW-1:0]    bits_left;
  logic [3:0]       run_len;
  logic             z_expect;

  modport master (
    output start, data, step,
    input  w_out, busy, done, bits_left, run_len, z_expect
  );

  modport slave (
    input  start, data, step,
    output w_out, busy, done, bits_left, run_len, z_expect
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - MSB-first frame serializer with run-length reference output
// Purpose: loads a WIDTH-bit frame on start, emits one bit per step=1 clock,
//   tracks the run of identical emitted bits and flags runs >= RUN.
// Ports:
//   clock      : rising-edge system clock
//   reset      : asynchronous, active-high reset
//   bus.start  : load request (honoured only in IDLE)
//   bus.data   : frame to transmit, MSB first
//   bus.step   : advance enable while shifting
//   bus.w_out  : registered serial bit
//   bus.busy   : frame in SHIFT
//   bus.done   : one-cycle pulse after the last bit
//   bus.bits_left : bits not yet emitted
//   bus.run_len   : consecutive identical bits ending with w_out (saturates at 15)
//   bus.z_expect  : run_len >= RUN
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int RUN   = 4
) (
  input  logic              clock,
  input  logic              reset,
  seq_pattern_tx_if.slave   bus
);
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_w_out;
  logic             r_busy;
  logic             r_done;
  logic [BW-1:0]    r_bits_left;
  logic [3:0]       r_run_len;
  logic             r_z_expect;

  logic             w_bit;
  logic [3:0]       w_next_run;
  logic             w_next_z;

  assign w_bit = r_shreg[WIDTH-1];

  // A zero run_len means nothing has been emitted since reset, so the first
  // bit always starts a fresh run even if it matches the reset value of w_out.
  always_comb begin
    w_next_run = 4'd1;
    if ((w_bit == r_w_out) && (r_run_len != 4'd0)) begin
      w_next_run = (r_run_len == 4'hF) ? 4'hF : r_run_len + 4'd1;
    end
  end

  assign w_next_z = (32'(w_next_run) >= RUN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_w_out     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bits_left <= '0;
      r_run_len   <= 4'd0;
      r_z_expect  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          // step is ignored here; start alone decides.
          if (bus.start) begin
            r_shreg     <= bus.data;
            r_bits_left <= BW'(WIDTH);
            r_busy      <= 1'b1;
            r_state     <= SHIFT;
          end
        end
        SHIFT: begin
          // step=0 leaves every register untouched (stall).
          if (bus.step) begin
            r_w_out     <= w_bit;
            r_shreg     <= {r_shreg[WIDTH-2:0], 1'b0};
            r_bits_left <= r_bits_left - BW'(1);
            r_run_len   <= w_next_run;
            r_z_expect  <= w_next_z;
            if (r_bits_left == BW'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.w_out     = r_w_out;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.bits_left = r_bits_left;
  assign bus.run_len   = r_run_len;
  assign bus.z_expect  = r_z_expect;
endmodule
